// File: rtl/mem_wr_arb_pkg.sv
// mem_wr_arb_pkg: shared widths, write-request record and grant helper for the memory write arbiter
package mem_wr_arb_pkg;
  localparam int ALEN = 16;
  localparam int XLEN = 16;
  typedef struct packed {
    logic [ALEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [1:0]      be;
  } wr_req_t;
  typedef enum logic {GNT0 = 1'b0, GNT1 = 1'b1} grant_t;
  function automatic grant_t next_grant(logic v0, logic v1, grant_t last);
    return (v0 && v1) ? (last == GNT0 ? GNT1 : GNT0) : (v1 ? GNT1 : GNT0);
  endfunction
endpackage

// File: rtl/mem_wr_arb_if.sv
// mem_wr_arb_if: two requester write channels plus the memory write port and busy flag
interface mem_wr_arb_if;
  import mem_wr_arb_pkg::*;
  logic            req0_valid;
  logic            req0_ready;
  logic [ALEN-1:0] req0_addr;
  logic [XLEN-1:0] req0_data;
  logic [1:0]      req0_be;
  logic            req1_valid;
  logic            req1_ready;
  logic [ALEN-1:0] req1_addr;
  logic [XLEN-1:0] req1_data;
  logic [1:0]      req1_be;
  logic [ALEN-1:0] mem_wr_addr;
  logic [XLEN-1:0] mem_wr_data;
  logic [1:0]      mem_wr_en;
  logic            busy;
  modport master (
    output req0_valid, req0_addr, req0_data, req0_be,
    output req1_valid, req1_addr, req1_data, req1_be,
    input  req0_ready, req1_ready, mem_wr_addr, mem_wr_data, mem_wr_en, busy
  );
  modport slave (
    input  req0_valid, req0_addr, req0_data, req0_be,
    input  req1_valid, req1_addr, req1_data, req1_be,
    output req0_ready, req1_ready, mem_wr_addr, mem_wr_data, mem_wr_en, busy
  );
endinterface

// File: rtl/mem_wr_arb_wr_fifo.sv
// wr_fifo: in-order queue of write requests with wrap-bit pointers for full/empty
module wr_fifo
  import mem_wr_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  logic    pop,
  input  wr_req_t din,
  output wr_req_t head,
  output logic    empty,
  output logic    full
);
  localparam int AW = $clog2(DEPTH);
  wr_req_t      store [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = store[rd_ptr[AW-1:0]];
  // advance pointers; callers never push when full nor pop when empty
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  // entry storage needs no reset: empty pointers mask stale contents
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/mem_wr_arb.sv
// mem_wr_arb: round-robin arbiter draining two request queues into a registered memory write stage
module mem_wr_arb
  import mem_wr_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  mem_wr_arb_if.slave bus
);
  wr_req_t in0, in1, head0, head1, win, stage;
  logic    empty0, empty1, full0, full1, push0, push1, pop0, pop1, any, stage_valid;
  grant_t  last_grant, sel;
  assign in0   = '{addr: bus.req0_addr, data: bus.req0_data, be: bus.req0_be};
  assign in1   = '{addr: bus.req1_addr, data: bus.req1_data, be: bus.req1_be};
  assign push0 = bus.req0_valid && !full0 && |bus.req0_be;
  assign push1 = bus.req1_valid && !full1 && |bus.req1_be;
  wr_fifo #(.DEPTH(DEPTH)) q0 (
    .clk(clk), .reset(reset), .push(push0), .pop(pop0), .din(in0),
    .head(head0), .empty(empty0), .full(full0)
  );
  wr_fifo #(.DEPTH(DEPTH)) q1 (
    .clk(clk), .reset(reset), .push(push1), .pop(pop1), .din(in1),
    .head(head1), .empty(empty1), .full(full1)
  );
  // choose one valid head, alternating only when both contend
  always_comb begin
    any  = !empty0 || !empty1;
    sel  = next_grant(!empty0, !empty1, last_grant);
    pop0 = any && sel == GNT0;
    pop1 = any && sel == GNT1;
    win  = sel == GNT1 ? head1 : head0;
  end
  // write stage reloads every cycle; grant history moves only on a grant
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant  <= GNT1;
      stage_valid <= 1'b0;
      stage       <= '0;
    end else begin
      stage_valid <= any;
      if (any) begin
        stage      <= win;
        last_grant <= sel;
      end
    end
  end
  assign bus.req0_ready  = !full0;
  assign bus.req1_ready  = !full1;
  assign bus.mem_wr_addr = stage.addr;
  assign bus.mem_wr_data = stage.data;
  assign bus.mem_wr_en   = stage_valid ? stage.be : 2'b00;
  assign bus.busy        = any || stage_valid;
endmodule

// File: tb/tb_mem_wr_arb.sv
// tb_mem_wr_arb: directed self-checking bench with a byte memory fed by the write port
module tb_mem_wr_arb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int errors = 0;
  logic [7:0]  mem [1024];
  logic [15:0] log_addr [64];
  int log_n = 0;
  mem_wr_arb_if bus();
  mem_wr_arb #(.DEPTH(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  // byte-enabled synchronous memory plus a log of written addresses
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else begin
      if (bus.mem_wr_en[0]) mem[bus.mem_wr_addr[9:0]] <= bus.mem_wr_data[7:0];
      if (bus.mem_wr_en[1]) mem[10'(bus.mem_wr_addr + 16'd1)] <= bus.mem_wr_data[15:8];
    end
    if (|bus.mem_wr_en) begin
      log_addr[log_n[5:0]] <= bus.mem_wr_addr;
      log_n <= log_n + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0; bus.req0_be = 2'b00;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0; bus.req1_be = 2'b00;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL reset_ready0: got %b want 1", bus.req0_ready); end
    vectors++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL reset_ready1: got %b want 1", bus.req1_ready); end
    vectors++; if (bus.mem_wr_en !== 2'b00) begin errors++; $display("FAIL reset_en: got %b want 00", bus.mem_wr_en); end
    vectors++; if (bus.mem_wr_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", bus.mem_wr_addr); end
    vectors++; if (bus.mem_wr_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", bus.mem_wr_data); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_single();
    bus.req0_valid = 1'b1; bus.req0_addr = 16'h0100; bus.req0_data = 16'hBEEF; bus.req0_be = 2'b11;
    vectors++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", bus.req0_ready); end
    tick();
    idle();
    vectors++; if (bus.mem_wr_en !== 2'b00) begin errors++; $display("FAIL single_en_e0: got %b want 00", bus.mem_wr_en); end
    vectors++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_e0: got %b want 1", bus.busy); end
    tick();
    vectors++; if (bus.mem_wr_en !== 2'b11) begin errors++; $display("FAIL single_en_e1: got %b want 11", bus.mem_wr_en); end
    vectors++; if (bus.mem_wr_addr !== 16'h0100) begin errors++; $display("FAIL single_addr: got %h want 0100", bus.mem_wr_addr); end
    vectors++; if (bus.mem_wr_data !== 16'hBEEF) begin errors++; $display("FAIL single_data: got %h want beef", bus.mem_wr_data); end
    tick();
    vectors++; if (bus.mem_wr_en !== 2'b00) begin errors++; $display("FAIL single_en_e2: got %b want 00", bus.mem_wr_en); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_e2: got %b want 0", bus.busy); end
    vectors++; if ({mem[10'h101], mem[10'h100]} !== 16'hBEEF) begin errors++; $display("FAIL single_mem: got %h want beef", {mem[10'h101], mem[10'h100]}); end
  endtask

  task automatic test_byte_enable();
    bus.req0_valid = 1'b1; bus.req0_addr = 16'h0101; bus.req0_data = 16'h12AB; bus.req0_be = 2'b01;
    tick();
    idle();
    tick();
    vectors++; if (bus.mem_wr_en !== 2'b01) begin errors++; $display("FAIL be_en: got %b want 01", bus.mem_wr_en); end
    vectors++; if (bus.mem_wr_addr !== 16'h0101) begin errors++; $display("FAIL be_addr: got %h want 0101", bus.mem_wr_addr); end
    tick();
    vectors++; if (mem[10'h101] !== 8'hAB) begin errors++; $display("FAIL be_low_byte: got %h want ab", mem[10'h101]); end
    vectors++; if (mem[10'h102] !== 8'h00) begin errors++; $display("FAIL be_high_byte: got %h want 00", mem[10'h102]); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL be_busy: got %b want 0", bus.busy); end
    bus.req0_valid = 1'b1; bus.req0_addr = 16'h0104; bus.req0_data = 16'hFFFF; bus.req0_be = 2'b00;
    vectors++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL be0_ready: got %b want 1", bus.req0_ready); end
    tick();
    idle();
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL be0_busy_a: got %b want 0", bus.busy); end
    tick();
    vectors++; if (bus.mem_wr_en !== 2'b00) begin errors++; $display("FAIL be0_en: got %b want 00", bus.mem_wr_en); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL be0_busy_b: got %b want 0", bus.busy); end
    tick();
    vectors++; if ({mem[10'h105], mem[10'h104]} !== 16'h0000) begin errors++; $display("FAIL be0_mem: got %h want 0000", {mem[10'h105], mem[10'h104]}); end
  endtask

  task automatic test_contention();
    int i0 = 0, i1 = 0, base;
    logic a0, a1, saw0 = 1'b0, saw1 = 1'b0;
    logic [15:0] exp;
    do_reset();
    base = log_n;
    for (int c = 0; c < 40 && (i0 < 4 || i1 < 4 || bus.busy); c++) begin
      bus.req0_valid = i0 < 4; bus.req0_addr = 16'h0300 + 16'(2 * i0); bus.req0_data = {8'hA0, 8'(i0)}; bus.req0_be = 2'b11;
      bus.req1_valid = i1 < 4; bus.req1_addr = 16'h0380 + 16'(2 * i1); bus.req1_data = {8'hB0, 8'(i1)}; bus.req1_be = 2'b11;
      if (!bus.req0_ready) saw0 = 1'b1;
      if (!bus.req1_ready) saw1 = 1'b1;
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      tick();
      i0 += int'(a0);
      i1 += int'(a1);
    end
    idle();
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cont_drain: busy %b want 0 (timeout)", bus.busy); end
    vectors++; if (log_n - base != 8) begin errors++; $display("FAIL cont_count: got %0d writes want 8", log_n - base); end
    for (int k = 0; k < 8; k++) begin
      exp = (k % 2 == 0) ? 16'h0300 + 16'(2 * (k / 2)) : 16'h0380 + 16'(2 * (k / 2));
      vectors++; if (log_addr[(base + k) % 64] !== exp) begin errors++; $display("FAIL cont_order[%0d]: got %h want %h", k, log_addr[(base + k) % 64], exp); end
    end
    vectors++; if (saw0 !== 1'b1) begin errors++; $display("FAIL cont_full0: saw_not_ready %b want 1", saw0); end
    vectors++; if (saw1 !== 1'b1) begin errors++; $display("FAIL cont_full1: saw_not_ready %b want 1", saw1); end
    vectors++; if ({mem[10'h307], mem[10'h306]} !== 16'hA003) begin errors++; $display("FAIL cont_mem: got %h want a003", {mem[10'h307], mem[10'h306]}); end
  endtask

  task automatic test_full();
    int j0 = 0, j1 = 0, base, c = 0;
    logic a0, hit = 1'b0;
    do_reset();
    base = log_n;
    while (c < 10 && bus.req1_ready) begin
      bus.req0_valid = 1'b1; bus.req0_addr = 16'h0310 + 16'(2 * j0); bus.req0_data = 16'h5500; bus.req0_be = 2'b11;
      bus.req1_valid = 1'b1; bus.req1_addr = 16'h0390 + 16'(2 * j1); bus.req1_data = 16'h6600; bus.req1_be = 2'b11;
      a0 = bus.req0_ready;
      tick();
      j0 += int'(a0);
      j1++;
      c++;
    end
    bus.req0_addr = 16'h0310 + 16'(2 * j0);
    bus.req1_addr = 16'h0390 + 16'(2 * j1);
    vectors++; if (j1 != 2) begin errors++; $display("FAIL full_accepted: got %0d want 2", j1); end
    vectors++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b want 0", bus.req1_ready); end
    a0 = bus.req0_ready;
    tick();
    j0 += int'(a0);
    vectors++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b want 1", bus.req1_ready); end
    vectors++; if (bus.mem_wr_addr !== 16'h0390) begin errors++; $display("FAIL full_grant_addr: got %h want 0390", bus.mem_wr_addr); end
    vectors++; if (bus.mem_wr_en !== 2'b11) begin errors++; $display("FAIL full_grant_en: got %b want 11", bus.mem_wr_en); end
    idle();
    for (int k = 0; k < 20 && bus.busy; k++) tick();
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL full_drain: busy %b want 0 (timeout)", bus.busy); end
    for (int k = base; k < log_n; k++) if (log_addr[k % 64] == 16'h0394) hit = 1'b1;
    vectors++; if (hit !== 1'b0) begin errors++; $display("FAIL full_refused: refused write landed %b want 0", hit); end
    vectors++; if (log_n - base != 5) begin errors++; $display("FAIL full_count: got %0d writes want 5", log_n - base); end
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_addr = 16'h0320; bus.req0_data = 16'h3333; bus.req0_be = 2'b11;
    bus.req1_valid = 1'b1; bus.req1_addr = 16'h03A0; bus.req1_data = 16'h4444; bus.req1_be = 2'b11;
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_addr = 16'h03A2;
    tick();
    idle();
    vectors++; if (bus.mem_wr_en !== 2'b11) begin errors++; $display("FAIL mid_stage_en: got %b want 11", bus.mem_wr_en); end
    vectors++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL mid_q1_full: ready %b want 0", bus.req1_ready); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    base = log_n;
    vectors++; if (bus.mem_wr_en !== 2'b00) begin errors++; $display("FAIL mid_en: got %b want 00", bus.mem_wr_en); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL mid_ready1: got %b want 1", bus.req1_ready); end
    for (int k = 0; k < 5; k++) tick();
    vectors++; if (log_n != base) begin errors++; $display("FAIL mid_no_write: got %0d writes want 0", log_n - base); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy_late: got %b want 0", bus.busy); end
  endtask

  task automatic test_same_addr();
    int base;
    do_reset();
    base = log_n;
    bus.req0_valid = 1'b1; bus.req0_addr = 16'h0200; bus.req0_data = 16'h1111; bus.req0_be = 2'b11;
    tick();
    bus.req0_data = 16'h2222;
    tick();
    idle();
    for (int k = 0; k < 10 && bus.busy; k++) tick();
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL race_drain: busy %b want 0 (timeout)", bus.busy); end
    vectors++; if ({mem[10'h201], mem[10'h200]} !== 16'h2222) begin errors++; $display("FAIL race_final: got %h want 2222", {mem[10'h201], mem[10'h200]}); end
    vectors++; if (log_n - base != 2) begin errors++; $display("FAIL race_count: got %0d writes want 2", log_n - base); end
  endtask

  initial begin
    idle();
    tick();
    test_reset();
    test_single();
    test_byte_enable();
    test_contention();
    test_full();
    test_reset_mid();
    test_same_addr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mem_wr_arb.md
# mem_wr_arb

Write-port arbiter for main memory. Two requesters share the memory's single synchronous, byte-enabled write port: requester 0 is the core store path and requester 1 is the loader/debug path. Each requester gets a small in-order queue. A round-robin arbiter drains the queue heads into a registered write stage that drives the memory write port directly. A `busy` flag lets the core hold dependent loads until all queued stores have landed.

## Interface
- `DEPTH`, 2, entries per requester queue; power of two, ≥2.
- `clk` in 1 — sole clock.
- `reset` in 1 — synchronous, active-high.
- `req0_valid` in 1 — requester 0 presents a write.
- `req0_ready` out 1 — requester 0 queue can accept.
- `req0_addr` in `ALEN` — byte address.
- `req0_data` in `XLEN` — write data; [7:0] goes to addr, [15:8] to addr+1.
- `req0_be` in 2 — byte enables, same encoding as the memory `wr_en`.
- `req1_valid`, `req1_ready`, `req1_addr`, `req1_data`, `req1_be` — same as requester 0.
- `mem_wr_addr` out `ALEN` — to memory `wr_addr_0`.
- `mem_wr_data` out `XLEN` — to memory `wr_data_0`.
- `mem_wr_en` out 2 — to memory `wr_en`.
- `busy` out 1 — any queue non-empty, or the write stage holds a valid write.

## Operation
- **Accept:** a request is accepted on an edge where `reqN_valid && reqN_ready`. `reqN_ready = !fullN`; it is not pop-aware, so a full queue refuses even in a cycle where it pops.
- **Zero enables:** a request with `be == 2'b00` is accepted and discarded. It is never enqueued and never written.
- **Arbitration:** each cycle, if at least one queue head is valid, exactly one head is popped and loaded into the write stage.
  - If both heads are valid, grant the requester not granted last.
  - `last_grant` resets to 1, so requester 0 wins the first contention.
  - `last_grant` updates only on a grant.
  - If only one head is valid, it is granted regardless of `last_grant`.
- **Write stage:** a register holding addr/data/be.
  - `mem_wr_en` is the registered `be` when the stage is valid, otherwise `2'b00`.
  - The stage loads every cycle: the new grant, or empty if there is none. There is no back-pressure from memory.
- **Ordering:** writes from one requester reach memory in acceptance order. There is no ordering guarantee between requesters beyond round-robin.
- **Pass-through:** address and data are passed unmodified. Odd addresses and address wrap at `MEMSZ` are the memory's concern.
- **Reset:** a reset asserted mid-operation flushes both queues and the write stage. Pending writes are dropped.

## Timing
- **Reset state** (all outputs, cycle after the reset edge):
  - `req0_ready = req1_ready = 1`
  - `mem_wr_en = 0`
  - `mem_wr_addr = 0`, `mem_wr_data = 0`
  - `busy = 0`
- **Write latency with empty queues:**
  - Accept at edge E0.
  - Head is granted and the write stage loads at E1.
  - `mem_wr_en` is asserted during the E1→E2 cycle.
  - Memory writes at E2, and async reads see the new data after E2.
  - Minimum accept-to-visible latency is therefore 2 edges.
- **Sustained throughput:** one write per cycle total, shared between requesters. Under continuous contention each requester gets every other cycle.
- **`busy` timing:** `busy` rises in the cycle after the accepting edge. It falls in the cycle after the edge on which the last write commits, i.e. it is low only once memory holds all accepted data.
- **Simultaneous events:** a push and a pop on the same queue in one cycle are legal whenever the queue is not full; occupancy is unchanged.
- **Full condition:** a queue holding `DEPTH` entries drives `ready` low in that same cycle.

## Structure
- **Shared package:** add `typedef struct packed {logic [ALEN-1:0] addr; logic [XLEN-1:0] data; logic [1:0] be;} wr_req_t;` to the project package. It is used by the core store path and the loader.
- **Sub-module `wr_fifo`:** a synchronous FIFO of `wr_req_t`, `DEPTH` entries, with pointers one bit wider than the index for full/empty detection. Outputs `head`, `empty`, `full`. Instantiated once per requester.
- **Top level:** the arbiter, `last_grant`, and the write stage live in `mem_wr_arb`.

## Test plan
- **Single write:** after reset, req0 writes addr 0x0100, data 0xBEEF, be 2'b11. Expect `mem_wr_en = 2'b11` for exactly one cycle, 1 cycle after acceptance. Reading 0x0100 then returns 0xBEEF, and `busy` drops the next cycle.
- **Byte enable:** req0 writes addr 0x0101, data 0x12AB, be 2'b01. Expect only 0x0101 to become 0xAB; 0x0102 is unchanged. A following request with be 2'b00 produces no `mem_wr_en` pulse and leaves `busy` low.
- **Contention:** req0 and req1 are held valid with 4 writes each. Expect memory write order r0,r1,r0,r1,…. Each requester's writes keep their address order, and `ready` drops while a queue is full.
- **Full queue:** req1 is blocked from draining by saturating req0 traffic, and req1 pushes until `ready = 0`. Expect exactly `DEPTH` entries accepted, with `ready` reasserting the cycle after a req1 grant.
- **Reset mid-stream:** with 2 entries queued plus an active write stage, assert reset for 1 cycle. Expect `mem_wr_en = 0` from the next cycle, no queued write ever reaching memory, and `busy = 0`.
- **Same-address race:** req0 writes 0x0200 ← 0x1111, then req0 writes 0x0200 ← 0x2222 in back-to-back cycles. Expect memory to finally hold 0x2222.
